// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, state encoding and legality check for the data-memory responder
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } dmem_state_e;

    // Width code must exist for the direction, and halfword/word accesses must be naturally aligned.
    function automatic logic access_legal(input logic we, input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_mux.sv
// rtl/dmem_lane_mux.sv - byte/half/word store merge and load extract on one 32-bit word
module dmem_lane_mux
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    assign byte_shift = old_word >> {addr_lo, 3'b000};
    assign half_shift = old_word >> {addr_lo[1], 4'b0000};

    // Store merge: replace only the addressed lanes, keep the rest of the old word.
    always_comb begin
        merged_word = old_word;
        case (funct3[1:0])
            2'b00: begin
                case (addr_lo)
                    2'd0:    merged_word[7:0]   = wdata[7:0];
                    2'd1:    merged_word[15:8]  = wdata[7:0];
                    2'd2:    merged_word[23:16] = wdata[7:0];
                    default: merged_word[31:24] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (addr_lo[1]) merged_word[31:16] = wdata[15:0];
                else            merged_word[15:0]  = wdata[15:0];
            end
            default: merged_word = wdata;
        endcase
    end

    // Load extract: move the selected lane(s) to bit 0 and extend by signedness.
    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
            F3_BU:   load_data = {24'd0, byte_shift[7:0]};
            F3_H:    load_data = {{16{half_shift[15]}}, half_shift[15:0]};
            F3_HU:   load_data = {16'd0, half_shift[15:0]};
            default: load_data = old_word;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data-memory responder with valid/ready request and response
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam int         AW        = ADDR_W + 2;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [31:0] mem_q [DEPTH];

    dmem_state_e state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          req_ready_q, req_ready_d;
    logic          busy_q, busy_d;

    logic          in_idle;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [2:0]    acc_f3;
    logic [31:0]   acc_wdata;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]   old_word;
    logic [31:0]   merged_word;
    logic [31:0]   load_data;
    logic          mem_we;
    logic          unused_addr_hi;

    // Address bits above the array are ignored so accesses alias modulo the depth.
    assign unused_addr_hi = ^req_addr[31:AW];

    // With zero wait states the access uses the live request; otherwise the captured one.
    assign in_idle   = (state_q == S_IDLE);
    assign acc_we    = in_idle ? req_we              : we_q;
    assign acc_addr  = in_idle ? req_addr[AW-1:0]    : addr_q;
    assign acc_f3    = in_idle ? req_funct3          : f3_q;
    assign acc_wdata = in_idle ? req_wdata           : wdata_q;
    assign acc_idx   = acc_addr[AW-1:2];
    assign old_word  = mem_q[acc_idx];

    dmem_lane_mux u_lane_mux (
        .addr_lo     (acc_addr[1:0]),
        .funct3      (acc_f3),
        .old_word    (old_word),
        .wdata       (acc_wdata),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    // Next-state logic: capture, wait countdown, access and response hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr[AW-1:0];
                    f3_d    = req_funct3;
                    wdata_d = req_wdata;
                    if (!access_legal(req_we, req_funct3, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        mem_we  = req_we;
                        err_d   = 1'b0;
                        rdata_d = req_we ? 32'd0 : load_data;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    mem_we  = we_q;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : load_data;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // Control and response registers; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            f3_q        <= 3'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Word array: not reset, and a store landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[acc_idx] <= merged_word;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench with byte-level memory model
module tb_data_mem_responder;

    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 2;
    localparam int NBYTES      = 4 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ref_byte [NBYTES];
    bit         ref_known [NBYTES];

    data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed memory, updated on legal stores only.
    task automatic ref_access(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output logic err, output bit known);
        int size;
        int base;
        bit legal;
        logic [31:0] val;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (legal && (addr % size) != 0) legal = 0;
        base  = int'(addr % NBYTES);
        rdata = 32'd0;
        err   = !legal;
        known = 1;
        if (legal && we) begin
            for (int i = 0; i < size; i++) begin
                ref_byte[base + i]  = wdata[8*i +: 8];
                ref_known[base + i] = 1;
            end
        end else if (legal) begin
            val = 32'd0;
            for (int i = 0; i < size; i++) begin
                val = val | (32'(ref_byte[base + i]) << (8 * i));
                if (!ref_known[base + i]) known = 0;
            end
            if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
            rdata = val;
        end
    endtask

    task automatic wait_req_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    // One full transaction: issue, measure latency, optionally stall the response, then complete.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wdata, input int hold, input bit early,
                          output logic [31:0] got);
        logic [31:0] er;
        logic        ee;
        bit          known;
        int          lat;
        ref_access(we, addr, f3, wdata, er, ee, known);
        wait_req_ready();
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = $urandom;
        req_funct3 = 3'($urandom);
        req_wdata  = $urandom;
        if (early) rsp_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 50);
        check("latency", lat, ee ? 1 : WAIT_CYCLES + 1);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
        if (known) check("rsp_rdata", rsp_rdata, er);
        check("busy_resp", {31'd0, busy}, 32'd1);
        check("req_ready_resp", {31'd0, req_ready}, 32'd0);
        got = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, got);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_done", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          hold;
        logic [2:0]  f3_tab [8];

        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};

        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("release_req_ready", {31'd0, req_ready}, 32'd1);

        // Word round trip
        do_req(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, 0, got);
        do_req(1'b0, 32'h10, 3'b010, 32'h0, 0, 0, got);
        check("plan_lw", got, 32'hDEADBEEF);

        // Byte/half extension
        do_req(1'b1, 32'h20, 3'b010, 32'h80FF7F01, 0, 0, got);
        do_req(1'b0, 32'h23, 3'b000, 32'h0, 0, 0, got);
        check("plan_lb", got, 32'hFFFFFF80);
        do_req(1'b0, 32'h23, 3'b100, 32'h0, 0, 0, got);
        check("plan_lbu", got, 32'h00000080);
        do_req(1'b0, 32'h22, 3'b001, 32'h0, 0, 0, got);
        check("plan_lh", got, 32'hFFFF80FF);
        do_req(1'b0, 32'h20, 3'b101, 32'h0, 0, 0, got);
        check("plan_lhu", got, 32'h00007F01);

        // Partial store merge
        do_req(1'b1, 32'h30, 3'b010, 32'h11223344, 0, 0, got);
        do_req(1'b1, 32'h31, 3'b000, 32'h000000AA, 0, 0, got);
        do_req(1'b1, 32'h32, 3'b001, 32'h0000BEEF, 0, 0, got);
        do_req(1'b0, 32'h30, 3'b010, 32'h0, 0, 0, got);
        check("plan_merge", got, 32'hBEEFAA44);

        // Errors
        do_req(1'b0, 32'h31, 3'b010, 32'h0, 0, 0, got);
        check("plan_mis_rdata", got, 32'h0);
        do_req(1'b1, 32'h32, 3'b010, 32'hFFFFFFFF, 0, 0, got);
        do_req(1'b0, 32'h30, 3'b010, 32'h0, 0, 0, got);
        check("plan_no_write", got, 32'hBEEFAA44);
        do_req(1'b0, 32'h30, 3'b011, 32'h0, 0, 0, got);

        // Backpressure and aliasing
        do_req(1'b0, 32'h10, 3'b010, 32'h0, 5, 0, got);
        do_req(1'b1, 32'h1000, 3'b010, 32'h5, 0, 0, got);
        do_req(1'b0, 32'h0, 3'b010, 32'h0, 0, 1, got);
        check("plan_alias", got, 32'h5);

        // Reset on the store commit edge
        do_req(1'b1, 32'h40, 3'b010, 32'hCAFEF00D, 0, 0, got);
        wait_req_ready();
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h40;
        req_funct3 = 3'b010;
        req_wdata  = 32'h1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rc_busy", {31'd0, busy}, 32'd0);
        check("rc_req_ready", {31'd0, req_ready}, 32'd0);
        check("rc_rdata", rsp_rdata, 32'd0);
        check("rc_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rc_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        do_req(1'b0, 32'h40, 3'b010, 32'h0, 0, 0, got);
        check("plan_rst_commit", got, 32'hCAFEF00D);

        // Randomized traffic over a small aliased window
        for (int n = 0; n < 300; n++) begin
            we   = 1'($urandom);
            f3   = f3_tab[$urandom_range(0, 7)];
            addr = ($urandom & 32'hFFFF_F000) | (($urandom % 16) << 2) | ($urandom % 4);
            if (($urandom % 3) != 0) begin
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
                if (f3[1:0] == 2'b01) addr[0]   = 1'b0;
            end
            hold = $urandom_range(0, 3);
            do_req(we, addr, f3, $urandom, hold, (hold == 0) && $urandom_range(0, 1) == 1, got);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
